// File: rtl/execute_stage_mc.sv
// rtl/execute_stage_mc.sv - MIPS-style execute stage with iterative MULTU/DIVU and HI/LO
module execute_stage_mc #(
    parameter int WIDTH   = 32,
    parameter int REGBITS = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               FlushE,
    input  logic               RegWriteE,
    input  logic               MemtoRegE,
    input  logic               MemWriteE,
    input  logic               ALUSrcE,
    input  logic               RegDstE,
    input  logic [3:0]         ALUControlE,
    input  logic [REGBITS-1:0] RtE,
    input  logic [REGBITS-1:0] RdE,
    input  logic [WIDTH-1:0]   RD1E,
    input  logic [WIDTH-1:0]   RD2E,
    input  logic [WIDTH-1:0]   SignImmE,
    input  logic [WIDTH-1:0]   ResultW,
    input  logic [1:0]         ForwardAE,
    input  logic [1:0]         ForwardBE,
    output logic [REGBITS-1:0] WriteRegE,
    output logic               BusyE,
    output logic               RegWriteM,
    output logic               MemtoRegM,
    output logic               MemWriteM,
    output logic [WIDTH-1:0]   ALUOutM,
    output logic [WIDTH-1:0]   WriteDataM,
    output logic [REGBITS-1:0] WriteRegM
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, stateNext;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] hiReg, loReg, accHi, accLo, operand;
    logic             opDiv;
    logic [WIDTH-1:0] srcA, srcB, writeDataE, aluOutE, stepHi, stepLo;
    logic [WIDTH:0]   mulSum, divShift, divTrial;
    logic             isMulDiv, issue, lastStep;

    always_comb begin
        case (ForwardAE)
            2'b01:   srcA = ResultW;
            2'b10:   srcA = ALUOutM;
            default: srcA = RD1E;
        endcase
        case (ForwardBE)
            2'b01:   writeDataE = ResultW;
            2'b10:   writeDataE = ALUOutM;
            default: writeDataE = RD2E;
        endcase
    end

    assign srcB      = ALUSrcE ? SignImmE : writeDataE;
    assign WriteRegE = RegDstE ? RdE : RtE;

    always_comb begin
        case (ALUControlE)
            4'b0000: aluOutE = srcA & srcB;
            4'b0001: aluOutE = srcA | srcB;
            4'b0010: aluOutE = srcA + srcB;
            4'b0011: aluOutE = srcA ^ srcB;
            4'b0100: aluOutE = ~(srcA | srcB);
            4'b0101: aluOutE = {{(WIDTH-1){1'b0}}, srcA < srcB};
            4'b0110: aluOutE = srcA - srcB;
            4'b0111: aluOutE = {{(WIDTH-1){1'b0}}, $signed(srcA) < $signed(srcB)};
            4'b1010: aluOutE = hiReg;
            4'b1011: aluOutE = loReg;
            default: aluOutE = '0;
        endcase
    end

    assign isMulDiv = (ALUControlE == 4'b1000) || (ALUControlE == 4'b1001);
    assign issue    = (state == IDLE) && isMulDiv && !FlushE;
    assign lastStep = (state == RUN) && (count == CW'(1));
    assign BusyE    = rst_n && (issue || ((state == RUN) && !FlushE));

    // One shift-add (multiply) or restoring subtract (divide) step on {accHi, accLo}
    always_comb begin
        mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : '0);
        divShift = {accHi, accLo[WIDTH-1]};
        divTrial = divShift - {1'b0, operand};
        stepHi   = mulSum[WIDTH:1];
        stepLo   = {mulSum[0], accLo[WIDTH-1:1]};
        if (opDiv) begin
            if (!divTrial[WIDTH]) begin
                stepHi = divTrial[WIDTH-1:0];
                stepLo = {accLo[WIDTH-2:0], 1'b1};
            end else begin
                stepHi = divShift[WIDTH-1:0];
                stepLo = {accLo[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        stateNext = state;
        if (FlushE) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE:    if (isMulDiv) stateNext = RUN;
                RUN:     if (count == CW'(1)) stateNext = DONE;
                DONE:    stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count   <= '0;
            hiReg   <= '0;
            loReg   <= '0;
            accHi   <= '0;
            accLo   <= '0;
            operand <= '0;
            opDiv   <= 1'b0;
        end else if (issue) begin
            count <= CW'(WIDTH);
            opDiv <= ALUControlE[0];
            accHi <= '0;
            // Divide shifts the dividend out of accLo; multiply shifts the multiplier out
            if (ALUControlE[0]) begin
                accLo   <= srcA;
                operand <= srcB;
            end else begin
                accLo   <= srcB;
                operand <= srcA;
            end
        end else if ((state == RUN) && !FlushE) begin
            count <= count - CW'(1);
            accHi <= stepHi;
            accLo <= stepLo;
            if (lastStep) begin
                hiReg <= stepHi;
                loReg <= stepLo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            RegWriteM  <= 1'b0;
            MemtoRegM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ALUOutM    <= '0;
            WriteDataM <= '0;
            WriteRegM  <= '0;
        end else begin
            ALUOutM    <= aluOutE;
            WriteDataM <= writeDataE;
            WriteRegM  <= WriteRegE;
            if (FlushE || BusyE) begin
                RegWriteM <= 1'b0;
                MemtoRegM <= 1'b0;
                MemWriteM <= 1'b0;
            end else begin
                RegWriteM <= RegWriteE;
                MemtoRegM <= MemtoRegE;
                MemWriteM <= MemWriteE;
            end
        end
    end
endmodule

// File: tb/tb_execute_stage_mc.sv
// tb/tb_execute_stage_mc.sv - scoreboard bench for execute_stage_mc against an arithmetic model
module tb_execute_stage_mc;
    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0, FlushE = 1'b0;
    logic        RegWriteE = 0, MemtoRegE = 0, MemWriteE = 0, ALUSrcE = 0, RegDstE = 0;
    logic [3:0]  ALUControlE = 0;
    logic [4:0]  RtE = 0, RdE = 0;
    logic [31:0] RD1E = 0, RD2E = 0, SignImmE = 0, ResultW = 0;
    logic [1:0]  ForwardAE = 0, ForwardBE = 0;
    logic [4:0]  WriteRegE, WriteRegM;
    logic        BusyE, RegWriteM, MemtoRegM, MemWriteM;
    logic [31:0] ALUOutM, WriteDataM;

    execute_stage_mc #(.WIDTH(32), .REGBITS(5)) dut (
        .clk(clk), .rst_n(rst_n), .FlushE(FlushE),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUControlE(ALUControlE),
        .RtE(RtE), .RdE(RdE), .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE),
        .ResultW(ResultW), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .WriteRegE(WriteRegE), .BusyE(BusyE), .RegWriteM(RegWriteM),
        .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM), .ALUOutM(ALUOutM),
        .WriteDataM(WriteDataM), .WriteRegM(WriteRegM)
    );

    logic       rstn8 = 1'b0, flush8 = 1'b1;
    logic [3:0] op8 = 4'd0;
    logic [7:0] a8 = 8'hFF, b8 = 8'h02;
    logic [4:0] wr8e, wr8m;
    logic       busy8, rw8, m2r8, mw8;
    logic [7:0] alu8m, wd8m;

    execute_stage_mc #(.WIDTH(8), .REGBITS(5)) dut8 (
        .clk(clk), .rst_n(rstn8), .FlushE(flush8),
        .RegWriteE(1'b1), .MemtoRegE(1'b0), .MemWriteE(1'b0),
        .ALUSrcE(1'b0), .RegDstE(1'b0), .ALUControlE(op8),
        .RtE(5'd3), .RdE(5'd4), .RD1E(a8), .RD2E(b8), .SignImmE(8'h00),
        .ResultW(8'h00), .ForwardAE(2'b00), .ForwardBE(2'b00),
        .WriteRegE(wr8e), .BusyE(busy8), .RegWriteM(rw8),
        .MemtoRegM(m2r8), .MemWriteM(mw8), .ALUOutM(alu8m),
        .WriteDataM(wd8m), .WriteRegM(wr8m)
    );

    typedef struct {
        logic        busy, cd, rw, m2r, mw;
        logic [31:0] alu, wd;
        logic [4:0]  wr;
    } exp_t;
    exp_t q[$];

    int errors = 0, checks = 0;
    logic [31:0] hiM = 0, loM = 0, aluM = 0;
    logic        aluKnown = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic push(input logic b, cd, rw, m2r, mw, input logic [31:0] alu, wd, input logic [4:0] wr);
        exp_t e;
        e.busy = b; e.cd = cd; e.rw = rw; e.m2r = m2r; e.mw = mw;
        e.alu = alu; e.wd = wd; e.wr = wr;
        q.push_back(e);
    endtask

    function automatic logic [31:0] fwdRef(input logic [1:0] s, input logic [31:0] rd, rw, am);
        if (s == 2'b01) return rw;
        if (s == 2'b10) return am;
        return rd;
    endfunction

    function automatic logic [31:0] aluRef(input logic [3:0] op, input logic [31:0] a, b);
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd3:  return a ^ b;
            4'd4:  return ~(a | b);
            4'd5:  return (a < b) ? 32'd1 : 32'd0;
            4'd6:  return a - b;
            4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd10: return hiM;
            4'd11: return loM;
            default: return 32'd0;
        endcase
    endfunction

    task automatic randomize_ctl();
        RegWriteE = 1'($urandom); MemtoRegE = 1'($urandom); MemWriteE = 1'($urandom);
        RegDstE = 1'($urandom); RtE = 5'($urandom); RdE = 5'($urandom);
    endtask

    task automatic reset_body();
        rst_n = 1'b0;
        FlushE = 1'($urandom);
        ALUControlE = 4'($urandom);
        randomize_ctl();
        push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        hiM = 0; loM = 0; aluM = 0; aluKnown = 1'b1;
    endtask

    task automatic apply_single(input logic [3:0] op, input logic [31:0] a1, a2, imm, rw,
                                input logic [1:0] fa, fb, input logic src, input logic flush);
        logic [31:0] sa, wd, sb, res;
        logic        md;
        @(negedge clk);
        rst_n = 1'b1; FlushE = flush;
        ALUControlE = op; RD1E = a1; RD2E = a2; SignImmE = imm; ResultW = rw;
        ForwardAE = fa; ForwardBE = fb; ALUSrcE = src;
        randomize_ctl();
        sa  = fwdRef(fa, a1, rw, aluM);
        wd  = fwdRef(fb, a2, rw, aluM);
        sb  = src ? imm : wd;
        md  = (op == 4'd8) || (op == 4'd9);
        res = aluRef(op, sa, sb);
        push(1'b0, !flush && !md, flush ? 1'b0 : RegWriteE, flush ? 1'b0 : MemtoRegE,
             flush ? 1'b0 : MemWriteE, res, wd, RegDstE ? RdE : RtE);
        aluM = res;
        aluKnown = !flush && !md;
    endtask

    task automatic rand_single(input logic flush);
        logic [3:0] op;
        logic [1:0] fa, fb;
        op = 4'($urandom_range(0, 15));
        if (!flush && (op == 4'd8 || op == 4'd9)) op = op + 4'd2;
        fa = 2'($urandom_range(0, 3));
        fb = 2'($urandom_range(0, 3));
        if (fa == 2'b10 && !aluKnown) fa = 2'b00;
        if (fb == 2'b10 && !aluKnown) fb = 2'b00;
        apply_single(op, $urandom, $urandom, $urandom, $urandom, fa, fb, 1'($urandom), flush);
    endtask

    task automatic apply_muldiv(input logic [3:0] op, input logic [31:0] a, b,
                                input int flushAt, input int rstAt);
        logic [63:0] p;
        for (int c = 0; c <= W + 1; c++) begin
            @(negedge clk);
            rst_n = 1'b1; FlushE = 1'b0;
            if (c == 0) begin
                ALUControlE = op; ForwardAE = 2'b01; ResultW = a; RD1E = $urandom;
                ForwardBE = 2'b00; RD2E = b; ALUSrcE = 1'b0; SignImmE = $urandom;
                randomize_ctl();
            end else begin
                ResultW = $urandom;
                ForwardAE = 2'($urandom_range(0, 3));
            end
            if (c == rstAt) begin
                reset_body();
                return;
            end
            if (c == flushAt) begin
                FlushE = 1'b1;
                push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
                aluKnown = 1'b0;
                return;
            end
            if (c <= W) push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
            else        push(1'b0, 1'b0, RegWriteE, MemtoRegE, MemWriteE, 32'd0, 32'd0, 5'd0);
        end
        if (op == 4'd8) begin
            p = {32'd0, a} * {32'd0, b};
            hiM = p[63:32]; loM = p[31:0];
        end else if (b == 32'd0) begin
            hiM = a; loM = 32'hFFFF_FFFF;
        end else begin
            hiM = a % b; loM = a / b;
        end
        aluKnown = 1'b0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("BusyE", {31'd0, BusyE}, {31'd0, e.busy});
                @(posedge clk);
                #1;
                chk("RegWriteM", {31'd0, RegWriteM}, {31'd0, e.rw});
                chk("MemtoRegM", {31'd0, MemtoRegM}, {31'd0, e.m2r});
                chk("MemWriteM", {31'd0, MemWriteM}, {31'd0, e.mw});
                if (e.cd) begin
                    chk("ALUOutM", ALUOutM, e.alu);
                    chk("WriteDataM", WriteDataM, e.wd);
                    chk("WriteRegM", {27'd0, WriteRegM}, {27'd0, e.wr});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int busyCnt, r, fl;
        logic [31:0] a, b;
        @(negedge clk);
        reset_body();
        apply_single(4'd2, 32'd7, 32'd5, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0);
        apply_single(4'd2, 32'hFFFF_FFFE, 32'd1, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0);
        apply_single(4'd2, 32'd123, 32'd0, 32'd1, 32'd0, 2'b10, 2'b00, 1'b1, 1'b0);
        apply_single(4'd2, 32'd40, 32'd2, 32'd0, 32'd9, 2'b11, 2'b11, 1'b0, 1'b0);
        apply_single(4'd6, 32'd0, 32'd8, 32'd0, 32'd50, 2'b01, 2'b00, 1'b0, 1'b0);
        apply_single(4'd7, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0);
        apply_single(4'd5, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0);
        apply_muldiv(4'd8, 32'hFFFF_FFFF, 32'd2, -1, -1);
        apply_single(4'd10, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0);
        apply_single(4'd11, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0);
        apply_muldiv(4'd9, 32'd100, 32'd7, -1, -1);
        apply_single(4'd11, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0);
        apply_single(4'd10, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0);
        apply_muldiv(4'd9, 32'd9, 32'd0, -1, -1);
        apply_single(4'd11, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0);
        apply_single(4'd10, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0);
        apply_muldiv(4'd8, 32'd12345, 32'd678, 10, -1);
        apply_single(4'd10, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0);
        apply_single(4'd8, 32'd3, 32'd3, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1);
        apply_single(4'd11, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0);
        apply_muldiv(4'd9, 32'd1000, 32'd3, -1, 5);
        apply_single(4'd10, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0);
        apply_single(4'd11, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 19);
            if (r < 2) begin
                a = $urandom;
                if ($urandom_range(0, 3) == 0)      b = 32'd0;
                else if ($urandom_range(0, 1) == 0) b = $urandom;
                else                                b = $urandom_range(1, 1000);
                fl = ($urandom_range(0, 7) == 0) ? $urandom_range(0, W) : -1;
                apply_muldiv((r == 0) ? 4'd8 : 4'd9, a, b, fl, -1);
                apply_single(4'd10, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0);
                apply_single(4'd11, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0);
            end else begin
                rand_single(r == 2);
            end
        end

        repeat (3) @(negedge clk);
        FlushE = 1'b1;
        ALUControlE = 4'd0;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end

        rstn8 = 1'b0; flush8 = 1'b0; op8 = 4'd0;
        repeat (2) @(negedge clk);
        rstn8 = 1'b1; op8 = 4'b1000;
        busyCnt = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!busy8) break;
            busyCnt++;
            @(negedge clk);
        end
        chk("busy8_cycles", busyCnt, 32'd9);
        @(negedge clk);
        op8 = 4'b1010;
        @(posedge clk);
        #1;
        chk("hi8", {24'd0, alu8m}, 32'h1);
        @(negedge clk);
        op8 = 4'b1011;
        @(posedge clk);
        #1;
        chk("lo8", {24'd0, alu8m}, 32'hFE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
